// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm_bank register file and its channel slices.
package pwm_pkg;

    localparam logic [1:0] OFF_PERIOD = 2'd0;
    localparam logic [1:0] OFF_DUTY   = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_STAT   = 2'd3;

    localparam logic [7:0] ADDR_GCTRL = 8'hF0;
    localparam logic [7:0] ADDR_ID    = 8'hF1;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_POL = 1;
    localparam int CTRL_CTR = 2;
    localparam int CTRL_IE  = 3;

    typedef struct packed {
        logic ie;
        logic ctr;
        logic pol;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/pwm_bank_if.sv
// Register bus shared with the sequencer: chip select, strobes, address and data.
interface pwm_bank_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cs;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;

    modport master (output cs, wr, rd, addr, d_in, input d_out);
    modport slave  (input cs, wr, rd, addr, d_in, output d_out);
endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: shadow/active period and duty, edge or centre counter,
// registered output and sticky period-end flag.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gen,
    input  logic             restart,
    input  logic             we_period,
    input  logic             we_duty,
    input  logic             we_ctrl,
    input  logic             clr_flag,
    input  logic [CNT_W-1:0] wdata,
    input  logic [3:0]       wctrl,
    output logic [CNT_W-1:0] period_s,
    output logic [CNT_W-1:0] duty_s,
    output logic [CNT_W-1:0] cnt,
    output ctrl_t            ctrl,
    output logic             flag,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] period_s_q, period_s_d, duty_s_q, duty_s_d;
    logic [CNT_W-1:0] period_a_q, period_a_d, duty_a_q, duty_a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             down_q, down_d, flag_q, flag_d, pwm_q, pwm_d;
    logic             act, eop, load;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        period_s_d = we_period ? wdata : period_s_q;
        duty_s_d   = we_duty ? wdata : duty_s_q;
        ctrl_d     = ctrl_q;
        if (we_ctrl) begin
            ctrl_d.en  = wctrl[CTRL_EN];
            ctrl_d.pol = wctrl[CTRL_POL];
            ctrl_d.ctr = wctrl[CTRL_CTR];
            ctrl_d.ie  = wctrl[CTRL_IE];
        end

        act    = ctrl_q.en & gen & (period_a_q != '0);
        cnt_d  = '0;
        down_d = 1'b0;
        eop    = 1'b0;
        if (act) begin
            if (!ctrl_q.ctr) begin
                if (cnt_q == period_a_q - ONE) eop = 1'b1;
                else cnt_d = cnt_q + ONE;
            end else if (down_q || cnt_q == period_a_q) begin
                // Descending leg; reaching 0 closes the period and turns back up.
                cnt_d  = cnt_q - ONE;
                down_d = (cnt_q != ONE);
                eop    = (cnt_q == ONE);
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
        if (restart || (we_ctrl && wctrl[CTRL_CTR] != ctrl_q.ctr)) begin
            cnt_d  = '0;
            down_d = 1'b0;
        end

        load       = !act || eop || restart;
        period_a_d = load ? period_s_q : period_a_q;
        duty_a_d   = load ? duty_s_q : duty_a_q;

        flag_d = flag_q;
        if (clr_flag) flag_d = 1'b0;
        if (eop)      flag_d = 1'b1;

        pwm_d = (act & (cnt_q < duty_a_q)) ^ ctrl_q.pol;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_s_q <= '0;
            duty_s_q   <= '0;
            period_a_q <= '0;
            duty_a_q   <= '0;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            down_q     <= 1'b0;
            flag_q     <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            period_s_q <= period_s_d;
            duty_s_q   <= duty_s_d;
            period_a_q <= period_a_d;
            duty_a_q   <= duty_a_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            down_q     <= down_d;
            flag_q     <= flag_d;
            pwm_q      <= pwm_d;
        end
    end

    assign period_s = period_s_q;
    assign duty_s   = duty_s_q;
    assign cnt      = cnt_q;
    assign ctrl     = ctrl_q;
    assign flag     = flag_q;
    assign pwm      = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: address decode, global control, registered readback
// and interrupt reduction around NCH pwm_chan slices.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NCH    = 8,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_bank_if.slave      bus,
    output logic [NCH-1:0] pwm,
    output logic           irq
);

    logic              wr_en, rd_en, gctrl_hit, restart;
    logic [ADDR_W-3:0] ch_idx;
    logic [1:0]        off;
    logic              gen_q, gen_d, irq_q, irq_d;
    logic [DATA_W-1:0] d_out_q, d_out_d, rdata;
    logic              unused_d_in;

    logic [CNT_W-1:0]  period_s [NCH];
    logic [CNT_W-1:0]  duty_s   [NCH];
    logic [CNT_W-1:0]  cnt      [NCH];
    ctrl_t             ctrl     [NCH];
    logic [NCH-1:0]    flag, ie;

    assign wr_en       = bus.cs & bus.wr;
    assign rd_en       = bus.cs & bus.rd;
    assign ch_idx      = bus.addr[ADDR_W-1:2];
    assign off         = bus.addr[1:0];
    assign gctrl_hit   = wr_en && (bus.addr == ADDR_W'(ADDR_GCTRL));
    assign restart     = gctrl_hit & bus.d_in[1];
    assign unused_d_in = ^bus.d_in;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic hit;
        assign hit   = wr_en && (ch_idx == (ADDR_W-2)'(i));
        assign ie[i] = ctrl[i].ie;

        pwm_chan #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .gen       (gen_q),
            .restart   (restart),
            .we_period (hit && off == OFF_PERIOD),
            .we_duty   (hit && off == OFF_DUTY),
            .we_ctrl   (hit && off == OFF_CTRL),
            .clr_flag  (hit && off == OFF_STAT && bus.d_in[0]),
            .wdata     (bus.d_in[CNT_W-1:0]),
            .wctrl     (bus.d_in[3:0]),
            .period_s  (period_s[i]),
            .duty_s    (duty_s[i]),
            .cnt       (cnt[i]),
            .ctrl      (ctrl[i]),
            .flag      (flag[i]),
            .pwm       (pwm[i])
        );
    end

    // Readback samples registered state only, so a same-cycle write is not visible.
    always_comb begin
        rdata = '0;
        if (bus.addr == ADDR_W'(ADDR_GCTRL)) begin
            rdata = DATA_W'(gen_q);
        end else if (bus.addr == ADDR_W'(ADDR_ID)) begin
            rdata = DATA_W'({8'(NCH), 8'(CNT_W)});
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_idx == (ADDR_W-2)'(i)) begin
                    case (off)
                        OFF_PERIOD: rdata = DATA_W'(period_s[i]);
                        OFF_DUTY:   rdata = DATA_W'(duty_s[i]);
                        OFF_CTRL:   rdata = DATA_W'(ctrl[i]);
                        default:    rdata = DATA_W'({cnt[i], 15'b0, flag[i]});
                    endcase
                end
            end
        end
        gen_d   = gctrl_hit ? bus.d_in[0] : gen_q;
        d_out_d = rd_en ? rdata : d_out_q;
        irq_d   = |(flag & ie);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_q   <= 1'b0;
            irq_q   <= 1'b0;
            d_out_q <= '0;
        end else begin
            gen_q   <= gen_d;
            irq_q   <= irq_d;
            d_out_q <= d_out_d;
        end
    end

    assign bus.d_out = d_out_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: edge/centre modes, shadowing, boundaries,
// flags/irq, restart and asynchronous reset, with hand-computed expectations.
module tb_pwm_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] pwm;
    logic       irq;
    int         n_checks;
    int         n_fail;
    int         seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    pwm_bank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    pwm_bank #(.NCH(8), .CNT_W(16), .DATA_W(32), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .pwm   (pwm),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the access lands on the following rising edge.
    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.cs = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic check_const(input string tag, input int ch, input logic exp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, 32'(pwm[ch]), 32'(exp));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.d_in = '0;
        #12;
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_dout", bus.d_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Edge mode: period 10, duty 3
        wr_reg(8'h00, 10);
        wr_reg(8'h01, 3);
        wr_reg(8'h02, 1);
        wr_reg(8'hF0, 1);
        check("edge_start", 32'(pwm[0]), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("edge_pwm", 32'(pwm[0]), ((k - 1) % 10 < 3) ? 32'h1 : 32'h0);
        end
        rd_reg(8'h03);
        check("edge_stat", bus.d_out, 32'h0000_0001);
        check("edge_irq", 32'(irq), 32'h0);

        // Shadow duty update mid-period takes effect only after the wrap
        wr_reg(8'h01, 7);
        check("shadow_pwm", 32'(pwm[0]), 32'h1);
        for (int k = 23; k <= 40; k++) begin
            @(negedge clk);
            check("shadow_pwm", 32'(pwm[0]),
                  ((k - 1) % 10 < ((k > 30) ? 7 : 3)) ? 32'h1 : 32'h0);
        end

        // Duty / period boundaries and polarity
        wr_reg(8'h01, 0);
        repeat (15) @(negedge clk);
        check_const("duty0", 0, 1'b0, 10);
        wr_reg(8'h01, 10);
        repeat (20) @(negedge clk);
        check_const("duty_full", 0, 1'b1, 10);
        wr_reg(8'h00, 0);
        repeat (20) @(negedge clk);
        check_const("period0", 0, 1'b0, 10);
        rd_reg(8'h03);
        check("period0_stat", bus.d_out, 32'h0000_0001);
        wr_reg(8'h02, 3);
        @(negedge clk);
        check_const("pol", 0, 1'b1, 5);
        wr_reg(8'h02, 0);

        // Centre mode on ch1: period 4, duty 2, counter streamed from STAT
        wr_reg(8'h04, 4);
        wr_reg(8'h05, 2);
        wr_reg(8'h06, 5);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 8'h07;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            check("ctr_cnt", 32'(bus.d_out[31:16]), 32'(seq[(j - 1) % 8]));
            check("ctr_pwm", 32'(pwm[1]), (seq[(j - 1) % 8] < 2) ? 32'h1 : 32'h0);
        end
        bus.cs = 1'b0; bus.rd = 1'b0;
        wr_reg(8'h06, 0);

        // Flags and irq on ch2: period 5, ie set
        wr_reg(8'h08, 5);
        wr_reg(8'h09, 1);
        wr_reg(8'h0A, 9);
        repeat (4) @(negedge clk);
        check("irq_before", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_latency", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        wr_reg(8'h0B, 1);
        check("irq_clr_lat", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_clr", 32'(irq), 32'h0);
        @(negedge clk);
        wr_reg(8'h0B, 1);
        check("irq_setwin_lat", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_setwin", 32'(irq), 32'h1);
        rd_reg(8'h0B);
        check("flag_setwin", bus.d_out, 32'h0001_0001);
        wr_reg(8'h0A, 0);
        wr_reg(8'h0B, 1);
        @(negedge clk);
        check("irq_off", 32'(irq), 32'h0);

        // Restart aligns ch0 (period 6) and ch1 (period 4)
        wr_reg(8'h00, 6);
        wr_reg(8'h01, 3);
        wr_reg(8'h02, 1);
        wr_reg(8'h05, 2);
        wr_reg(8'h06, 1);
        repeat (3) @(negedge clk);
        wr_reg(8'hF0, 3);
        for (int m = 1; m <= 12; m++) begin
            @(negedge clk);
            check("rst_ch0", 32'(pwm[0]), ((m - 1) % 6 < 3) ? 32'h1 : 32'h0);
            check("rst_ch1", 32'(pwm[1]), ((m - 1) % 4 < 2) ? 32'h1 : 32'h0);
        end
        rd_reg(8'hF0);
        check("gctrl_read", bus.d_out, 32'h1);
        check("mid_pulse", 32'(pwm[0]), 32'h1);

        // Asynchronous reset mid-pulse
        #2 rst_n = 1'b0;
        #1;
        check("async_pwm", 32'(pwm), 32'h0);
        check("async_dout", bus.d_out, 32'h0);
        check("async_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_pwm", 32'(pwm), 32'h0);
        end
        rd_reg(8'hF1);
        check("id", bus.d_out, 32'h0000_0810);
        rd_reg(8'hF0);
        check("gctrl_rst", bus.d_out, 32'h0);
        rd_reg(8'h40);
        check("unmapped", bus.d_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
